// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control FSM: states, opcodes
// and the datapath mux / ALU-op encodings.
package rv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_e;

  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format implied by the opcode; R-type and unknown ops give I.
  function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
    logic [SEL_W-1:0] imm;
    imm = IMM_I;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared memory port with a ready handshake.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [SEL_W-1:0] result_src,
  output logic [SEL_W-1:0] alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic [SEL_W-1:0] imm_src,
  output logic [SEL_W-1:0] alu_op,
  output logic             retire,
  output logic             illegal
);

  state_e state_q, state_d;

  // State register; reset parks the FSM in RESET and abandons any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Output decode: Moore on state, with fetch strobes gated by mem_ready and
  // the branch PC load taken straight from the ALU zero flag.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = imm_src_of(op);
    alu_op     = ALUOP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_RESET: imm_src = IMM_I;
      S_FETCH: begin
        mem_req    = 1'b1;
        result_src = RES_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        retire     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_TRAP: begin
        imm_src = IMM_I;
        illegal = 1'b1;
      end
      default: begin
        imm_src = IMM_I;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output
// traces built from the instruction class and a planned mem_ready schedule.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
  logic       retire, illegal;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic mr;
    logic z;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         wf, wd, cyc, regw, pcw, memw;
  } vec_t;

  ctl_t  act;
  step_t trace[$];
  vec_t  tbl[10];

  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_op, retire, illegal};

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011, BEQ_OP = 7'b1100011, JAL_OP = 7'b1101111;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input int idx, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%05h exp=%05h", name, idx, got, exp);
    end
  endtask

  function automatic logic [1:0] m_imm(input logic [6:0] o);
    case (o)
      SW_OP:   return 2'b01;
      BEQ_OP:  return 2'b10;
      JAL_OP:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t c, input logic mr, input logic z);
    step_t s;
    s.exp = c; s.mr = mr; s.z = z;
    trace.push_back(s);
  endtask

  // Expected cycle-by-cycle outputs for one instruction, with wf fetch waits,
  // wd data waits and ntrap cycles observed after an illegal decode.
  task automatic build(input logic [6:0] o, input logic z, input int wf, input int wd,
                       input int ntrap);
    ctl_t c;
    logic [1:0] im;
    im = m_imm(o);
    trace.delete();
    c = '0; c.mem_req = 1; c.result_src = 2'b10; c.alu_src_b = 2'b10; c.imm_src = im;
    repeat (wf) push(c, 1'b0, rbit());
    c.ir_write = 1; c.pc_write = 1;
    push(c, 1'b1, rbit());
    c = '0; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = im;
    push(c, rbit(), rbit());
    case (o)
      R_OP, I_OP: begin
        c = '0; c.imm_src = im; c.alu_src_a = 2'b10; c.alu_op = 2'b10;
        c.alu_src_b = (o == I_OP) ? 2'b01 : 2'b00;
        push(c, rbit(), rbit());
        c = '0; c.imm_src = im; c.reg_write = 1; c.retire = 1;
        push(c, rbit(), rbit());
      end
      LW_OP, SW_OP: begin
        c = '0; c.imm_src = im; c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
        push(c, rbit(), rbit());
        c = '0; c.imm_src = im; c.mem_req = 1; c.adr_src = 1; c.mem_write = (o == SW_OP);
        repeat (wd) push(c, 1'b0, rbit());
        c.retire = (o == SW_OP);
        push(c, 1'b1, rbit());
        if (o == LW_OP) begin
          c = '0; c.imm_src = im; c.result_src = 2'b01; c.reg_write = 1; c.retire = 1;
          push(c, rbit(), rbit());
        end
      end
      BEQ_OP: begin
        c = '0; c.imm_src = im; c.alu_src_a = 2'b10; c.alu_op = 2'b01;
        c.pc_write = z; c.retire = 1;
        push(c, rbit(), z);
      end
      JAL_OP: begin
        c = '0; c.imm_src = im; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1;
        push(c, rbit(), rbit());
        c = '0; c.imm_src = im; c.reg_write = 1; c.retire = 1;
        push(c, rbit(), rbit());
      end
      default: begin
        c = '0; c.illegal = 1;
        repeat (ntrap) push(c, rbit(), rbit());
      end
    endcase
  endtask

  // Plays the trace (or its first nsteps entries) and tallies DUT strobes.
  task automatic run(input string name, input logic [6:0] o, input int nsteps,
                     output int cyc, output int regw, output int pcw,
                     output int memw, output int ret);
    cyc = 0; regw = 0; pcw = 0; memw = 0; ret = 0;
    for (int i = 0; i < trace.size() && (nsteps == 0 || i < nsteps); i++) begin
      @(posedge clk); #1;
      op = o; mem_ready = trace[i].mr; zero = trace[i].z;
      #1;
      chk_ctl(name, i, act, trace[i].exp);
      if (reg_write) regw++;
      if (pc_write)  pcw++;
      if (mem_write) memw++;
      if (retire) begin
        ret++;
        if (cyc == 0) cyc = i + 1;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1 chk("reset_async_outputs", int'(act), 0);
    @(posedge clk); #1;
    chk("reset_hold_outputs", int'(act), 0);
    rst_n = 1'b1;
    #1 chk("reset_release_outputs", int'(act), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=1 exp=0");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, regw, pcw, memw, ret;
    logic [6:0] ops[6];
    rst_n = 1'b0; op = LW_OP; zero = 1'b0; mem_ready = 1'b1;
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = LW_OP; ops[3] = SW_OP; ops[4] = BEQ_OP; ops[5] = JAL_OP;

    tbl[0] = '{R_OP,   1'b0, 0, 0,  4, 1, 1, 0};
    tbl[1] = '{I_OP,   1'b0, 0, 0,  4, 1, 1, 0};
    tbl[2] = '{LW_OP,  1'b0, 3, 2, 10, 1, 1, 0};
    tbl[3] = '{SW_OP,  1'b0, 0, 2,  6, 0, 1, 3};
    tbl[4] = '{BEQ_OP, 1'b1, 0, 0,  3, 0, 2, 0};
    tbl[5] = '{BEQ_OP, 1'b0, 0, 0,  3, 0, 1, 0};
    tbl[6] = '{JAL_OP, 1'b0, 0, 0,  4, 1, 2, 0};
    tbl[7] = '{LW_OP,  1'b0, 0, 0,  5, 1, 1, 0};
    tbl[8] = '{SW_OP,  1'b0, 0, 0,  4, 0, 1, 1};
    tbl[9] = '{I_OP,   1'b0, 2, 0,  6, 1, 1, 0};

    #3;
    apply_reset();

    foreach (tbl[k]) begin
      build(tbl[k].op, tbl[k].z, tbl[k].wf, tbl[k].wd, 0);
      run("vec_trace", tbl[k].op, 0, cyc, regw, pcw, memw, ret);
      chk("vec_cycles", cyc, tbl[k].cyc);
      chk("vec_reg_writes", regw, tbl[k].regw);
      chk("vec_pc_writes", pcw, tbl[k].pcw);
      chk("vec_mem_write_cycles", memw, tbl[k].memw);
      chk("vec_retires", ret, 1);
    end

    // Illegal opcode: absorbing trap, then reset restarts cleanly.
    build(7'b0000000, 1'b0, 0, 0, 22);
    run("trap_trace", 7'b0000000, 0, cyc, regw, pcw, memw, ret);
    chk("trap_retires", ret, 0);
    chk("trap_reg_writes", regw, 0);
    chk("trap_mem_writes", memw, 0);
    chk("trap_pc_writes", pcw, 1);
    apply_reset();
    build(R_OP, 1'b0, 0, 0, 0);
    run("post_trap_trace", R_OP, 0, cyc, regw, pcw, memw, ret);
    chk("post_trap_cycles", cyc, 4);

    // Reset while MEMREAD is waiting on the memory.
    build(LW_OP, 1'b0, 0, 5, 0);
    run("abort_trace", LW_OP, 5, cyc, regw, pcw, memw, ret);
    chk("abort_no_retire", ret, 0);
    apply_reset();
    build(LW_OP, 1'b0, 1, 1, 0);
    run("post_abort_trace", LW_OP, 0, cyc, regw, pcw, memw, ret);
    chk("post_abort_cycles", cyc, 7);

    // Random instruction stream with random handshake stalls.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 5)];
      build(o, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      run("rand_trace", o, 0, cyc, regw, pcw, memw, ret);
      chk("rand_retires", ret, 1);
      chk("rand_cycles", cyc, trace.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle RV32 control FSM. It replaces the single-cycle main decode and sequences a shared-memory multicycle datapath: PC register, instruction register, one ALU, and a unified instruction/data memory port with a ready handshake. Supports R-type, I-type ALU, lw, sw, beq and jal. Any other opcode traps.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- op  in  7  opcode from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe, valid with mem_req
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load instruction register and old-PC register
- pc_write  out  1  load PC
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- alu_op  out  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  high while in TRAP

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Outputs are Moore decodes of state. Exceptions:
  - ir_write and pc_write in FETCH are gated by mem_ready.
  - pc_write in BEQ equals zero.
  - imm_src decodes from op in every state. Unknown op gives 00.
- Any output not listed for a state is 0.
- RESET: all outputs 0, go to FETCH.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Hold while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Dispatch on op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready. On the mem_ready cycle retire=1, go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, go to ALUWB.
- EXECI: same as EXECR except alu_src_b=01, go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, retire=1, go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, go to ALUWB (rd ← oldPC+4).
- TRAP: illegal=1, all other outputs 0. Absorbing; only rst_n exits.

## Timing
- State register is the only sequential element. Outputs are combinational from state plus zero/mem_ready. The path mem_ready→ir_write/pc_write is combinational by design.
- rst_n low: state=RESET asynchronously and all outputs 0. First FETCH occurs in the cycle after rst_n deasserts.
- Latency with mem_ready tied high:
  - R, I, jal: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
- Each wait cycle on mem_ready adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Handshake:
  - mem_req, adr_src and mem_write stay stable until mem_ready is sampled high.
  - mem_ready is ignored when mem_req=0.
  - Exactly one access completes per mem_ready cycle.
- Reset mid-access: the access is abandoned and no strobes fire. The memory must tolerate a dropped request.
- Exactly one retire pulse per non-trapping instruction. No retire in TRAP.

## Structure
- Shared package rv_ctrl_pkg holds:
  - state enum
  - opcode localparams (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL)
  - encodings for result_src, alu_src_a, alu_src_b, imm_src and alu_op
- The ALU decoder stays separate and consumes alu_op. No sub-module inside this block: one next-state process and one output process.

## Test plan
- R-type (op=0110011), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; reg_write and retire high in cycle 4 only.
- lw (op=0000011), mem_ready low for 3 cycles in FETCH and 2 in MEMREAD → ir_write on the 4th FETCH cycle; reg_write with result_src=01 in MEMWB; total 10 cycles.
- sw (op=0100011), mem_ready delayed 2 cycles → mem_write=1 and adr_src=1 held for 3 cycles; reg_write never asserted.
- beq (op=1100011) with zero=1 → pc_write=1 in BEQ. Repeat with zero=0 → pc_write=0; retire still pulses.
- jal (op=1101111) → pc_write=1 in JAL, then reg_write=1 in ALUWB with result_src=00.
- op=0000000 → TRAP, illegal stays 1 for 20+ cycles with no strobes. Then rst_n pulse → RESET, FETCH.
- Reset asserted in MEMREAD → outputs drop to 0 in the same cycle; fetch restarts cleanly.
